// File: rtl/bcd_counter_multi_digit_visual_test.sv
// Multi-digit BCD up/down counter for a board-level visual test.
// A free-running divider makes a one-cycle tick enable from CLOCK_50; on each
// enabled tick the BCD count moves by one, wrapping or saturating at 0 / M-1.
// Digits drive active-low seven-segment displays with optional leading-zero
// blanking. LEDG mirrors the low 8 bits of the count in binary.
module bcd_counter_multi_digit_visual_test #(
    parameter int DIGITS = 4,
    parameter int M      = 10000,
    parameter int TICK_M = 50000000,
    parameter int TICK_N = 26
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  wrap_mode,
    input  logic                  blank_en,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [1:0]            LEDR,
    output logic [7:0]            LEDG,
    output logic                  sat
);

    localparam logic [TICK_N-1:0] TICK_LAST = TICK_N'(TICK_M - 1);
    localparam logic [7:0]        MAX_LOW   = 8'((M - 1) % 256);

    // Active-low gfedcba pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [TICK_N-1:0]          r_div;
    logic                       w_tick;
    logic                       w_step;
    logic                       r_tick_sq;
    logic                       r_cpl;
    logic                       r_sat;
    logic [7:0]                 r_bin;
    logic [DIGITS-1:0][3:0]     r_digit;

    logic [DIGITS-1:0][3:0]     w_inc;
    logic [DIGITS-1:0][3:0]     w_dec;
    logic [DIGITS-1:0][3:0]     w_maxval;
    logic [DIGITS-1:0]          w_carry;
    logic [DIGITS-1:0]          w_borrow;
    logic [DIGITS-1:0]          w_is_zero;
    logic [DIGITS-1:0]          w_is_nine;
    logic [DIGITS-1:0]          w_is_max;
    logic [DIGITS-1:0]          w_zero_above;
    logic                       w_at_zero;
    logic                       w_at_max;

    logic [DIGITS-1:0][3:0]     w_digit_next;
    logic [7:0]                 w_bin_next;
    logic                       w_sat_next;
    logic                       w_cpl_next;

    assign w_tick = (r_div == TICK_LAST);
    assign w_step = w_tick & enable;

    // Free-running tick divider, independent of enable.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Per-digit ripple carry/borrow, bound detection and blanking chain.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam logic [3:0] MAXD = 4'(((M - 1) / (10 ** gi)) % 10);

            assign w_is_zero[gi] = (r_digit[gi] == 4'd0);
            assign w_is_nine[gi] = (r_digit[gi] == 4'd9);
            assign w_is_max[gi]  = (r_digit[gi] == MAXD);
            assign w_maxval[gi]  = MAXD;

            assign w_inc[gi] = !w_carry[gi]  ? r_digit[gi] :
                               (w_is_nine[gi] ? 4'd0 : r_digit[gi] + 4'd1);
            assign w_dec[gi] = !w_borrow[gi] ? r_digit[gi] :
                               (w_is_zero[gi] ? 4'd9 : r_digit[gi] - 4'd1);

            if (gi < DIGITS - 1) begin : g_chain
                assign w_carry[gi+1]   = w_carry[gi] & w_is_nine[gi];
                assign w_borrow[gi+1]  = w_borrow[gi] & w_is_zero[gi];
                assign w_zero_above[gi] = w_is_zero[gi] & w_zero_above[gi+1];
            end else begin : g_top
                assign w_zero_above[gi] = w_is_zero[gi];
            end

            // Digit 0 always shows; higher digits blank when they and everything above are zero.
            if (gi == 0) begin : g_lsd
                assign HEX[7*gi +: 7] = seg7(r_digit[gi]);
            end else begin : g_upper
                assign HEX[7*gi +: 7] = (blank_en && w_zero_above[gi]) ? 7'b1111111
                                                                         : seg7(r_digit[gi]);
            end
        end
    endgenerate

    assign w_at_zero = w_zero_above[0];
    assign w_at_max  = &w_is_max;

    // Next count, binary mirror, saturation flag and wrap pulse for this cycle.
    always_comb begin
        w_digit_next = r_digit;
        w_bin_next   = r_bin;
        w_sat_next   = r_sat;
        w_cpl_next   = 1'b0;
        if (w_step) begin
            if (up_down) begin
                if (w_at_max) begin
                    if (wrap_mode) begin
                        w_digit_next = '0;
                        w_bin_next   = 8'd0;
                        w_sat_next   = 1'b0;
                        w_cpl_next   = 1'b1;
                    end else begin
                        w_sat_next   = 1'b1;
                    end
                end else begin
                    w_digit_next = w_inc;
                    w_bin_next   = r_bin + 8'd1;
                    w_sat_next   = 1'b0;
                end
            end else begin
                if (w_at_zero) begin
                    if (wrap_mode) begin
                        w_digit_next = w_maxval;
                        w_bin_next   = MAX_LOW;
                        w_sat_next   = 1'b0;
                        w_cpl_next   = 1'b1;
                    end else begin
                        w_sat_next   = 1'b1;
                    end
                end else begin
                    w_digit_next = w_dec;
                    w_bin_next   = r_bin - 8'd1;
                    w_sat_next   = 1'b0;
                end
            end
        end
    end

    // Count state registers; reset wins over a coincident tick.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_digit   <= '0;
            r_bin     <= 8'd0;
            r_sat     <= 1'b0;
            r_cpl     <= 1'b0;
            r_tick_sq <= 1'b0;
        end else begin
            r_digit   <= w_digit_next;
            r_bin     <= w_bin_next;
            r_sat     <= w_sat_next;
            r_cpl     <= w_cpl_next;
            if (w_tick) begin
                r_tick_sq <= ~r_tick_sq;
            end
        end
    end

    assign LEDR = {r_cpl, r_tick_sq};
    assign LEDG = r_bin;
    assign sat  = r_sat;

endmodule

// File: tb/tb_bcd_counter_multi_digit_visual_test.sv
// Bench for the BCD visual-test counter. Two instances: A (2 digits, M=12,
// tick every 4 cycles) and B (4 digits, M=10000, tick every 2 cycles).
// Expected outputs come from an integer-count model of the counting rules.
module tb_bcd_counter_multi_digit_visual_test;

    logic        clk = 1'b0;
    logic [1:0]  rst, en, ud, wr, bl;
    logic [13:0] hex_a;
    logic [27:0] hex_b;
    logic [1:0]  ledr_a, ledr_b;
    logic [7:0]  ledg_a, ledg_b;
    logic        sat_a, sat_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_counter_multi_digit_visual_test #(.DIGITS(2), .M(12), .TICK_M(4), .TICK_N(3)) dut_a (
        .CLOCK_50(clk), .reset(rst[0]), .enable(en[0]), .up_down(ud[0]),
        .wrap_mode(wr[0]), .blank_en(bl[0]),
        .HEX(hex_a), .LEDR(ledr_a), .LEDG(ledg_a), .sat(sat_a));

    bcd_counter_multi_digit_visual_test #(.DIGITS(4), .M(10000), .TICK_M(2), .TICK_N(2)) dut_b (
        .CLOCK_50(clk), .reset(rst[1]), .enable(en[1]), .up_down(ud[1]),
        .wrap_mode(wr[1]), .blank_en(bl[1]),
        .HEX(hex_b), .LEDR(ledr_b), .LEDG(ledg_b), .sat(sat_b));

    // Reference model state, one slot per instance.
    int  tick_m [2] = '{4, 2};
    int  mod_m  [2] = '{12, 10000};
    int  m_div  [2];
    int  m_cnt  [2];
    bit  m_sat  [2];
    bit  m_sq   [2];
    bit  m_cpl  [2];

    logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    function automatic void model_update(int id);
        bit tick;
        if (rst[id]) begin
            m_div[id] = 0; m_cnt[id] = 0; m_sat[id] = 0; m_sq[id] = 0; m_cpl[id] = 0;
            return;
        end
        tick = (m_div[id] == tick_m[id] - 1);
        m_div[id] = tick ? 0 : m_div[id] + 1;
        m_cpl[id] = 0;
        if (!tick) return;
        m_sq[id] = !m_sq[id];
        if (!en[id]) return;
        if (ud[id]) begin
            if (m_cnt[id] == mod_m[id] - 1) begin
                if (wr[id]) begin m_cnt[id] = 0; m_cpl[id] = 1; m_sat[id] = 0; end
                else m_sat[id] = 1;
            end else begin
                m_cnt[id]++; m_sat[id] = 0;
            end
        end else begin
            if (m_cnt[id] == 0) begin
                if (wr[id]) begin m_cnt[id] = mod_m[id] - 1; m_cpl[id] = 1; m_sat[id] = 0; end
                else m_sat[id] = 1;
            end else begin
                m_cnt[id]--; m_sat[id] = 0;
            end
        end
    endfunction

    // Expected display word from a decimal value.
    function automatic logic [55:0] exp_hex(int cnt, int nd, bit blank);
        logic [55:0] r = '1;
        int msd = 0;
        int p = 1;
        int d;
        for (int k = 0; k < nd; k++) begin
            if ((cnt / p) % 10 != 0) msd = k;
            p = p * 10;
        end
        p = 1;
        for (int k = 0; k < nd; k++) begin
            d = (cnt / p) % 10;
            r[7*k +: 7] = (blank && k > msd) ? 7'b1111111 : seg_tbl[d];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        for (int id = 0; id < 2; id++) model_update(id);
        #1;
    endtask

    task automatic reset_both();
        rst = 2'b11;
        step();
        rst = 2'b00;
    endtask

    task automatic test_reset();
        logic [55:0] e;
        en = 2'b00; ud = 2'b11; wr = 2'b11; bl = 2'b10;
        reset_both();
        n_checks++; if (ledg_a !== 8'd0 || ledg_b !== 8'd0) begin n_fail++; $display("FAIL reset_ledg: got %0d/%0d want 0/0", ledg_a, ledg_b); end
        n_checks++; if (ledr_a !== 2'b00 || ledr_b !== 2'b00) begin n_fail++; $display("FAIL reset_ledr: got %b/%b want 00/00", ledr_a, ledr_b); end
        n_checks++; if (sat_a !== 1'b0 || sat_b !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b/%b want 0/0", sat_a, sat_b); end
        n_checks++; if (hex_a !== 14'b1000000_1000000) begin n_fail++; $display("FAIL reset_hex_a: got %b want %b", hex_a, 14'b1000000_1000000); end
        e = exp_hex(0, 4, 1'b1);
        n_checks++; if (hex_b !== e[27:0]) begin n_fail++; $display("FAIL reset_hex_b: got %h want %h", hex_b, e[27:0]); end
        $display("test_reset done");
    endtask

    task automatic test_up_wrap();
        logic [55:0] e;
        int pulses = 0;
        reset_both();
        en[0] = 1; ud[0] = 1; wr[0] = 1; bl[0] = 0;
        for (int c = 0; c < 52; c++) begin
            step();
            e = exp_hex(m_cnt[0], 2, bl[0]);
            n_checks++;
            if (ledg_a !== 8'(m_cnt[0]) || hex_a !== e[13:0] || ledr_a !== {m_cpl[0], m_sq[0]} || sat_a !== m_sat[0]) begin
                n_fail++; $display("FAIL up_wrap c=%0d: got ledg=%0d hex=%b ledr=%b sat=%b want ledg=%0d hex=%b ledr=%b%b sat=%b",
                                   c, ledg_a, hex_a, ledr_a, sat_a, m_cnt[0], e[13:0], m_cpl[0], m_sq[0], m_sat[0]);
            end
            if (ledr_a[1]) begin
                pulses++;
                n_checks++; if (ledg_a !== 8'd0) begin n_fail++; $display("FAIL up_wrap_pulse_count: got %0d want 0", ledg_a); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL up_wrap_pulses: got %0d want 1", pulses); end
        $display("test_up_wrap done pulses=%0d", pulses);
    endtask

    task automatic test_down_wrap();
        reset_both();
        en[0] = 1; ud[0] = 0; wr[0] = 1; bl[0] = 0;
        repeat (4) step();
        n_checks++; if (ledg_a !== 8'd11) begin n_fail++; $display("FAIL down_wrap_ledg: got %0d want 11", ledg_a); end
        n_checks++; if (hex_a !== 14'b1111001_1111001) begin n_fail++; $display("FAIL down_wrap_hex: got %b want %b", hex_a, 14'b1111001_1111001); end
        n_checks++; if (ledr_a[1] !== 1'b1) begin n_fail++; $display("FAIL down_wrap_pulse: got %b want 1", ledr_a[1]); end
        step();
        n_checks++; if (ledr_a[1] !== 1'b0) begin n_fail++; $display("FAIL down_wrap_pulse_width: got %b want 0", ledr_a[1]); end
        $display("test_down_wrap done count=%0d", ledg_a);
    endtask

    task automatic test_saturate();
        int pulses = 0;
        reset_both();
        en[0] = 1; ud[0] = 1; wr[0] = 0; bl[0] = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (ledr_a[1]) pulses++;
            n_checks++;
            if (ledg_a !== 8'(m_cnt[0]) || sat_a !== m_sat[0]) begin
                n_fail++; $display("FAIL saturate c=%0d: got ledg=%0d sat=%b want %0d/%b", c, ledg_a, sat_a, m_cnt[0], m_sat[0]);
            end
        end
        n_checks++; if (ledg_a !== 8'd11 || sat_a !== 1'b1) begin n_fail++; $display("FAIL saturate_hold: got %0d/%b want 11/1", ledg_a, sat_a); end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL saturate_pulses: got %0d want 0", pulses); end
        ud[0] = 0;
        repeat (4) step();
        n_checks++; if (ledg_a !== 8'd10 || sat_a !== 1'b0) begin n_fail++; $display("FAIL saturate_release: got %0d/%b want 10/0", ledg_a, sat_a); end
        $display("test_saturate done count=%0d", ledg_a);
    endtask

    task automatic test_carry();
        reset_both();
        en[1] = 1; ud[1] = 1; wr[1] = 1; bl[1] = 0;
        repeat (198) step();
        n_checks++; if (ledg_b !== 8'd99) begin n_fail++; $display("FAIL carry_99: got %0d want 99", ledg_b); end
        en[1] = 0;
        repeat (20) step();
        n_checks++; if (ledg_b !== 8'd99 || hex_b !== 28'b1000000_1000000_0010000_0010000) begin
            n_fail++; $display("FAIL carry_hold: got %0d hex=%b want 99", ledg_b, hex_b); end
        en[1] = 1;
        repeat (2) step();
        n_checks++; if (ledg_b !== 8'd100) begin n_fail++; $display("FAIL carry_100: got %0d want 100", ledg_b); end
        bl[1] = 1; #1;
        n_checks++; if (hex_b !== 28'b1111111_1111001_1000000_1000000) begin
            n_fail++; $display("FAIL carry_hex: got %b want %b", hex_b, 28'b1111111_1111001_1000000_1000000); end
        $display("test_carry done count=%0d", ledg_b);
    endtask

    task automatic test_blank();
        reset_both();
        en[1] = 1; ud[1] = 1; wr[1] = 1;
        repeat (10) step();
        en[1] = 0; bl[1] = 1; #1;
        n_checks++; if (hex_b !== 28'b1111111_1111111_1111111_0010010) begin
            n_fail++; $display("FAIL blank_on: got %b want %b", hex_b, 28'b1111111_1111111_1111111_0010010); end
        bl[1] = 0; #1;
        n_checks++; if (hex_b !== 28'b1000000_1000000_1000000_0010010) begin
            n_fail++; $display("FAIL blank_off: got %b want %b", hex_b, 28'b1000000_1000000_1000000_0010010); end
        $display("test_blank done");
    endtask

    task automatic test_reset_tick();
        reset_both();
        en[0] = 1; ud[0] = 1; wr[0] = 1;
        repeat (28) step();
        n_checks++; if (ledg_a !== 8'd7) begin n_fail++; $display("FAIL rtick_pre: got %0d want 7", ledg_a); end
        repeat (3) step();
        rst[0] = 1;
        step();
        rst[0] = 0;
        n_checks++; if (ledg_a !== 8'd0 || ledr_a !== 2'b00 || sat_a !== 1'b0) begin
            n_fail++; $display("FAIL rtick_clear: got ledg=%0d ledr=%b sat=%b want 0/00/0", ledg_a, ledr_a, sat_a); end
        repeat (3) step();
        n_checks++; if (ledg_a !== 8'd0) begin n_fail++; $display("FAIL rtick_early: got %0d want 0", ledg_a); end
        step();
        n_checks++; if (ledg_a !== 8'd1) begin n_fail++; $display("FAIL rtick_first: got %0d want 1", ledg_a); end
        $display("test_reset_tick done");
    endtask

    task automatic test_random();
        logic [55:0] ea, eb;
        reset_both();
        for (int c = 0; c < 3000; c++) begin
            for (int id = 0; id < 2; id++) begin
                if ($urandom_range(7) == 0) begin
                    en[id] = ($urandom_range(3) != 0);
                    ud[id] = $urandom_range(1);
                    wr[id] = $urandom_range(1);
                    bl[id] = $urandom_range(1);
                end
                rst[id] = ($urandom_range(199) == 0);
            end
            step();
            ea = exp_hex(m_cnt[0], 2, bl[0]);
            eb = exp_hex(m_cnt[1], 4, bl[1]);
            n_checks++;
            if (ledg_a !== 8'(m_cnt[0]) || hex_a !== ea[13:0] || ledr_a !== {m_cpl[0], m_sq[0]} || sat_a !== m_sat[0]) begin
                n_fail++; $display("FAIL random_a c=%0d: got ledg=%0d hex=%b ledr=%b sat=%b want ledg=%0d hex=%b ledr=%b%b sat=%b",
                                   c, ledg_a, hex_a, ledr_a, sat_a, m_cnt[0] % 256, ea[13:0], m_cpl[0], m_sq[0], m_sat[0]);
            end
            n_checks++;
            if (ledg_b !== 8'(m_cnt[1] % 256) || hex_b !== eb[27:0] || ledr_b !== {m_cpl[1], m_sq[1]} || sat_b !== m_sat[1]) begin
                n_fail++; $display("FAIL random_b c=%0d: got ledg=%0d hex=%h ledr=%b sat=%b want ledg=%0d hex=%h ledr=%b%b sat=%b",
                                   c, ledg_b, hex_b, ledr_b, sat_b, m_cnt[1] % 256, eb[27:0], m_cpl[1], m_sq[1], m_sat[1]);
            end
        end
        rst = 2'b00;
        $display("test_random done count_a=%0d count_b=%0d", m_cnt[0], m_cnt[1]);
    endtask

    initial begin
        rst = 2'b11; en = 2'b00; ud = 2'b11; wr = 2'b11; bl = 2'b00;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_carry();
        test_blank();
        test_reset_tick();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_multi_digit_visual_test.md
Name: bcd_counter_multi_digit_visual_test

Overview:
Board-level visual-test top for a parametrised multi-digit decimal up/down counter. It generates its own tick enable from CLOCK_50 and counts 0..M-1 in BCD across DIGITS seven-segment displays. It supports direction control, pause, wrap or saturate at the bounds, and leading-zero blanking. Everything runs in the single CLOCK_50 domain; the tick is a clock enable, never a derived clock.

Parameters:
DIGITS, 4, number of BCD digits and seven-segment displays (1..8)
M, 10000, modulus: count range 0..M-1; must satisfy 2 <= M <= 10**DIGITS
TICK_M, 50000000, CLOCK_50 cycles per count tick (1 s at 50 MHz); >= 2
TICK_N, 26, tick divider width; 2**TICK_N >= TICK_M

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = count on tick, 0 = hold count
up_down  in  1  1 = count up, 0 = count down
wrap_mode  in  1  1 = wrap at bounds, 0 = saturate at bounds
blank_en  in  1  1 = blank leading zeros
HEX  out  7*DIGITS  seven-segment outputs, active-low, digit k at HEX[7k+6:7k], bit order gfedcba
LEDR  out  2  [0] tick square wave, [1] complete_tick pulse
LEDG  out  8  binary count[7:0] (low bits of the count)
sat  out  1  saturated-at-bound indicator

Behaviour:
- Reset is sampled on the CLOCK_50 rising edge and has priority over all other inputs.
- Reset values: tick divider 0; all BCD digits 0; LEDR = 2'b00; sat 0; LEDG 0.
- HEX after reset: digit 0 shows "0" (1000000). Digits 1..DIGITS-1 show "0" when blank_en=0 and are blank (1111111) when blank_en=1.
- Tick divider: counts 0..TICK_M-1 and wraps. tick is high for exactly 1 cycle when the divider equals TICK_M-1. The divider runs regardless of enable.
- LEDR[0] toggles on every tick cycle.
- The count updates only on cycles where tick=1 and enable=1. Latency: the new count is visible on LEDG and HEX in the cycle after the tick edge (registered count, combinational decode).
- BCD arithmetic, up: digit 0 increments. A digit at 9 goes to 0 and carries to the next digit. Digits are never outside 0..9.
- BCD arithmetic, down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Up at bound (count = M-1):
  - wrap_mode=1: count goes to 0 and LEDR[1] pulses high for 1 cycle.
  - wrap_mode=0: count holds at M-1, sat=1, no pulse.
- Down at bound (count = 0):
  - wrap_mode=1: count goes to M-1 and LEDR[1] pulses high for 1 cycle.
  - wrap_mode=0: count holds at 0, sat=1, no pulse.
- sat is registered and updated on every tick with enable=1. It clears on the first tick that moves the count.
- up_down, wrap_mode and enable are sampled only on tick cycles. A change takes effect at the next qualifying tick.
- LEDG holds the binary equivalent of the count, truncated to 8 bits. It is registered alongside the BCD digits and updated by +1/-1, wrapping to M-1 or 0 in step with the BCD count.
- Blanking:
  - With blank_en=1, each zero digit above the most-significant non-zero digit is blanked.
  - Digit 0 is never blanked.
  - blank_en acts combinationally on HEX.
- Segment codes for 0..9, active-low gfedcba: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Reset mid-operation: a reset asserted in the same cycle as a tick wins. Count becomes 0, no complete pulse, divider restarts at 0.

Test Plan:
- DIGITS=2, M=12, TICK_M=4, up, wrap, from reset:
  - tick every 4th cycle; LEDR[0] toggles each tick.
  - count sequence 00..11 on HEX, then 00.
  - LEDR[1] high exactly 1 cycle, at the 11 -> 0 transition.
- Same configuration, down, wrap, from reset: first tick gives count 11 (HEX1=1111001, HEX0=1111001, LEDG=8'd11) and a LEDR[1] pulse.
- Saturate (wrap_mode=0), up, 20 ticks:
  - count stops at 11; sat=1; no LEDR[1] pulse.
  - switch up_down=0: next tick gives 10 and sat=0.
- DIGITS=4, M=10000, TICK_M=2, count up to 0099, enable=0 for 10 ticks:
  - count holds at 0099 while disabled.
  - re-enable: next tick shows 0100 (carry over two digits).
  - blank_en=1 shows HEX3 blank, HEX2=1111001, HEX1/HEX0=1000000.
- Count 5, DIGITS=4, blank_en=1: HEX3..HEX1=1111111, HEX0=0010010. Toggle blank_en=0: HEX3..HEX1=1000000.
- Reset asserted coincident with a tick at count 7: next cycle count=0, LEDR=00, sat=0; the divider restarts and the first tick arrives TICK_M cycles after reset deasserts.
